// File: rtl/p_shfrot_seq_pkg.sv
// Shared types for the iterative packed shift/rotate unit: FSM states, fill modes
// and pack-width decode helpers used by both the top and the barrel stage.
package p_shfrot_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic {
    FILL_ZERO = 1'b0,
    FILL_SIGN = 1'b1
  } fill_e;

  // Index of the set bit of a one-hot pack width (highest set bit otherwise).
  function automatic int unsigned oh_idx(input logic [31:0] v);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) idx = unsigned'(i);
    end
    return idx;
  endfunction

  // Offset mask inside one element (EW-1); OR-ing it into a bit index yields the element MSB.
  function automatic int unsigned elem_mask(input int unsigned xlen, input logic [31:0] pw);
    return (xlen >> oh_idx(pw)) - 1;
  endfunction

endpackage

// File: rtl/p_shfrot_stage.sv
// One combinational barrel stage: moves every element by 2^k, never across element bounds.
// Zero latency, no flow control; the sign-fill path exists only with P_SHFROT_ARITH_EN.
module p_shfrot_stage
  import p_shfrot_seq_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int LOGX = $clog2(XLEN)
) (
  input  logic [XLEN-1:0] data_i,
  input  logic [LOGX-1:0] pw,
  input  logic [LOGX-1:0] k,
  input  logic            left,
  input  logic            rot,
`ifdef P_SHFROT_ARITH_EN
  input  fill_e           fill,
`endif
  output logic [XLEN-1:0] data_o
);

  logic [LOGX-1:0] msk, step, jj, off, base, src;

  always_comb begin
    msk    = LOGX'(elem_mask(XLEN, 32'(pw)));
    step   = LOGX'(1) << k;
    jj     = '0;
    off    = '0;
    base   = '0;
    src    = '0;
    data_o = '0;
    for (int j = 0; j < XLEN; j++) begin
      jj   = LOGX'(j);
      off  = jj & msk;
      base = jj & ~msk;
      src  = '0;
      if (rot) begin
        // Rotates are always normalised to the right; wrap modulo EW inside the element.
        src       = base | ((off + step) & msk);
        data_o[j] = data_i[src];
      end else if (left) begin
        if (off >= step) begin
          src       = jj - step;
          data_o[j] = data_i[src];
        end
      end else if (off <= msk - step) begin
        src       = jj + step;
        data_o[j] = data_i[src];
      end
`ifdef P_SHFROT_ARITH_EN
      else if (fill == FILL_SIGN) begin
        src       = jj | msk;
        data_o[j] = data_i[src];
      end
`endif
    end
  end

endmodule

// File: rtl/p_shfrot_seq.sv
// Iterative packed shift/rotate: one barrel stage per cycle, log2(EW) BUSY cycles per op.
// Valid/ready on both sides; result held while out_valid && !out_ready. Option: P_SHFROT_ARITH_EN.
module p_shfrot_seq
  import p_shfrot_seq_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int LOGX = $clog2(XLEN)
) (
  input  logic            g_clk,
  input  logic            g_resetn,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] crs1,
  input  logic [LOGX-1:0] shamt,
  input  logic [LOGX-1:0] pw,
  input  logic            shift,
  input  logic            rotate,
  input  logic            left,
  input  logic            right,
`ifdef P_SHFROT_ARITH_EN
  input  logic            arith,
`endif
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] data_q, data_d;
  logic [LOGX-1:0] amt_q, amt_d, cnt_q, cnt_d, pw_q, pw_d;
  logic            left_q, left_d, rot_q, rot_d;
`ifdef P_SHFROT_ARITH_EN
  fill_e           fill_q, fill_d;
`endif
  logic            accept, legal, amt_bit;
  logic [LOGX-1:0] msk_in, shamt_mod, last_cnt;
  logic [XLEN-1:0] fill_val, stage_out;

  assign accept   = in_valid && in_ready && !flush;
  assign amt_bit  = |(amt_q & (LOGX'(1) << cnt_q));
  assign last_cnt = LOGX'(LOGX - 1 - int'(oh_idx(32'(pw_q))));

  always_comb begin
    legal = $onehot(pw) && (shift ^ rotate) && (left ^ right);
`ifdef P_SHFROT_ARITH_EN
    if (arith && !(shift && right)) legal = 1'b0;
`endif
  end

  always_comb begin
    msk_in    = LOGX'(elem_mask(XLEN, 32'(pw)));
    shamt_mod = shamt & msk_in;
    fill_val  = '0;
`ifdef P_SHFROT_ARITH_EN
    for (int j = 0; j < XLEN; j++) begin
      if (arith) fill_val[j] = crs1[LOGX'(j) | msk_in];
    end
`endif
  end

  p_shfrot_stage #(.XLEN(XLEN), .LOGX(LOGX)) u_stage (
    .data_i (data_q),
    .pw     (pw_q),
    .k      (cnt_q),
    .left   (left_q),
    .rot    (rot_q),
`ifdef P_SHFROT_ARITH_EN
    .fill   (fill_q),
`endif
    .data_o (stage_out)
  );

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = legal ? ST_BUSY : ST_DONE;
      ST_BUSY: if (cnt_q == last_cnt) state_d = ST_DONE;
      ST_DONE: begin
        if (accept)         state_d = legal ? ST_BUSY : ST_DONE;
        else if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    out_valid = (state_q == ST_DONE);
    busy      = (state_q != ST_IDLE);
    result    = data_q;
  end

  always_comb begin
    data_d = data_q;
    amt_d  = amt_q;
    cnt_d  = cnt_q;
    pw_d   = pw_q;
    left_d = left_q;
    rot_d  = rot_q;
`ifdef P_SHFROT_ARITH_EN
    fill_d = fill_q;
`endif
    if (accept) begin
      cnt_d  = '0;
      pw_d   = pw;
      rot_d  = rotate;
      left_d = shift && left;
`ifdef P_SHFROT_ARITH_EN
      fill_d = arith ? FILL_SIGN : FILL_ZERO;
`endif
      if (!legal) begin
        data_d = '0;
        amt_d  = '0;
      end else if (rotate) begin
        data_d = crs1;
        amt_d  = left ? ((LOGX'(0) - shamt_mod) & msk_in) : shamt_mod;
      end else if (shamt > msk_in) begin
        // Over-range shift: preload the fill and let the stages run as no-ops.
        data_d = fill_val;
        amt_d  = '0;
      end else begin
        data_d = crs1;
        amt_d  = shamt;
      end
    end else if (state_q == ST_BUSY) begin
      cnt_d = cnt_q + LOGX'(1);
      if (amt_bit) data_d = stage_out;
    end
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      data_q <= '0;
      amt_q  <= '0;
      cnt_q  <= '0;
      pw_q   <= '0;
      left_q <= 1'b0;
      rot_q  <= 1'b0;
`ifdef P_SHFROT_ARITH_EN
      fill_q <= FILL_ZERO;
`endif
    end else begin
      data_q <= data_d;
      amt_q  <= amt_d;
      cnt_q  <= cnt_d;
      pw_q   <= pw_d;
      left_q <= left_d;
      rot_q  <= rot_d;
`ifdef P_SHFROT_ARITH_EN
      fill_q <= fill_d;
`endif
    end
  end

endmodule

// File: tb/tb_p_shfrot_seq.sv
// Randomised bench for p_shfrot_seq against a per-element arithmetic model, plus directed cases.
module tb_p_shfrot_seq;

  logic        g_clk = 1'b0;
  logic        g_resetn = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid, busy;
  logic [31:0] crs1 = '0;
  logic [31:0] result;
  logic [4:0]  shamt = '0;
  logic [4:0]  pw = '0;
  logic        shift = 1'b0, rotate = 1'b0, left = 1'b0, right = 1'b0;
`ifdef P_SHFROT_ARITH_EN
  logic        arith = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 g_clk = ~g_clk;

  p_shfrot_seq #(.XLEN(32)) dut (
    .g_clk     (g_clk),
    .g_resetn  (g_resetn),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .crs1      (crs1),
    .shamt     (shamt),
    .pw        (pw),
    .shift     (shift),
    .rotate    (rotate),
    .left      (left),
    .right     (right),
`ifdef P_SHFROT_ARITH_EN
    .arith     (arith),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Element-wise reference; lat is the number of clock edges from accept to out_valid.
  function automatic logic [31:0] ref_op(input logic [31:0] a, input logic [4:0] sa,
                                         input logic [4:0] p, input logic sh, input logic ro,
                                         input logic le, input logic ri, input logic ar,
                                         output int lat);
    int ew, r;
    longint v, m, o, sv;
    logic [31:0] res;
    res = '0;
    lat = 0;
    if ($countones(p) != 1 || sh == ro || le == ri || (ar && !(sh && ri))) return '0;
    ew = 32;
    for (int i = 0; i < 5; i++) if (p[i]) ew = 32 >> i;
    lat = $clog2(ew);
    m = (longint'(1) << ew) - 1;
    for (int b = 0; b < 32; b += ew) begin
      v = longint'(a >> b) & m;
      r = int'(sa) % ew;
      if (ro) o = le ? (((v << r) | (v >> (ew - r))) & m) : (((v >> r) | (v << (ew - r))) & m);
      else if (int'(sa) >= ew) o = (ar && v[ew-1]) ? m : 0;
      else if (le) o = (v << sa) & m;
      else if (ar && v[ew-1]) begin
        sv = v - (longint'(1) << ew);
        o  = (sv >>> sa) & m;
      end else o = v >> sa;
      res = res | 32'(o << b);
    end
    return res;
  endfunction

  task automatic drive(input logic [31:0] a, input logic [4:0] sa, input logic [4:0] p,
                       input logic sh, input logic ro, input logic le, input logic ri,
                       input logic ar);
    crs1 = a; shamt = sa; pw = p;
    shift = sh; rotate = ro; left = le; right = ri;
`ifdef P_SHFROT_ARITH_EN
    arith = ar;
`endif
  endtask

  // Called at the negedge just after the accepting edge.
  task automatic wait_done(input string tag, input int exp_lat, input logic [31:0] exp_res,
                           input int hold, output logic [31:0] got);
    int lat;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge g_clk);
      lat++;
    end
    check({tag, ".lat"}, lat, exp_lat);
    check({tag, ".res"}, result, exp_res);
    got = result;
    for (int h = 0; h < hold; h++) begin
      @(negedge g_clk);
      check({tag, ".hold_vld"}, out_valid, 1);
      check({tag, ".hold_res"}, result, exp_res);
      check({tag, ".hold_rdy"}, in_ready, 0);
    end
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(negedge g_clk);
    out_ready = 1'b0;
    check({tag, ".idle_vld"}, out_valid, 0);
    check({tag, ".idle_rdy"}, in_ready, 1);
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [4:0] sa,
                        input logic [4:0] p, input logic sh, input logic ro, input logic le,
                        input logic ri, input logic ar, input int hold, output logic [31:0] got);
    int el;
    logic [31:0] er;
    er = ref_op(a, sa, p, sh, ro, le, ri, ar, el);
    @(negedge g_clk);
    drive(a, sa, p, sh, ro, le, ri, ar);
    in_valid = 1'b1;
    check({tag, ".rdy"}, in_ready, 1);
    @(negedge g_clk);
    in_valid = 1'b0;
    wait_done(tag, el, er, hold, got);
    consume(tag);
  endtask

  initial begin
    logic [31:0] got, ra;
    logic [4:0]  rp, rs;
    logic        s0, r0, l0, r1, ar;
    int          sel;

    #1 g_resetn = 1'b0;
    #1;
    check("rst.vld", out_valid, 0);
    check("rst.rdy", in_ready, 1);
    check("rst.busy", busy, 0);
    check("rst.res", result, 0);
    repeat (2) @(negedge g_clk);
    g_resetn = 1'b1;

    run_op("shl32", 32'h000000F1, 5'd4, 5'b00001, 1, 0, 1, 0, 0, 0, got);
    check("shl32.const", got, 32'h00000F10);
    run_op("rol8", 32'h8001FF10, 5'd3, 5'b00100, 0, 1, 1, 0, 0, 1, got);
    check("rol8.const", got, 32'h0408FF80);
    run_op("ror8", 32'h8001FF10, 5'd5, 5'b00100, 0, 1, 0, 1, 0, 0, got);
    check("ror8.const", got, 32'h0408FF80);
    run_op("shr16", 32'hFFFFFFFF, 5'd17, 5'b00010, 1, 0, 0, 1, 0, 0, got);
    check("shr16.const", got, 32'h00000000);
    run_op("illegal", 32'h12345678, 5'd1, 5'b00011, 1, 0, 1, 0, 0, 0, got);
    check("illegal.const", got, 32'h00000000);
`ifdef P_SHFROT_ARITH_EN
    run_op("sra8", 32'h807FF00C, 5'd2, 5'b00100, 1, 0, 0, 1, 1, 0, got);
    check("sra8.const", got, 32'hE01FFC03);
`endif

    // Back-pressure, then a new request accepted in the consuming cycle.
    @(negedge g_clk);
    drive(32'h000000F1, 5'd4, 5'b00001, 1, 0, 1, 0, 0);
    in_valid = 1'b1;
    @(negedge g_clk);
    in_valid = 1'b0;
    wait_done("bp", 5, 32'h00000F10, 3, got);
    drive(32'h8001FF10, 5'd3, 5'b00100, 0, 1, 1, 0, 0);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1 check("bp.rdy", in_ready, 1);
    @(negedge g_clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("bp.busy", busy, 1);
    check("bp.vld", out_valid, 0);
    wait_done("bp2", 3, 32'h0408FF80, 0, got);
    consume("bp2");

    // Flush mid-BUSY.
    @(negedge g_clk);
    drive(32'hCAFEF00D, 5'd7, 5'b00001, 1, 0, 1, 0, 0);
    in_valid = 1'b1;
    @(negedge g_clk);
    in_valid = 1'b0;
    @(negedge g_clk);
    flush = 1'b1;
    @(negedge g_clk);
    flush = 1'b0;
    check("fl.vld", out_valid, 0);
    check("fl.rdy", in_ready, 1);
    check("fl.busy", busy, 0);
    repeat (6) @(negedge g_clk);
    check("fl.late_vld", out_valid, 0);

    // Flush wins over a same-cycle accept.
    drive(32'h0000FFFF, 5'd1, 5'b00001, 0, 1, 0, 1, 0);
    in_valid = 1'b1;
    flush    = 1'b1;
    @(negedge g_clk);
    in_valid = 1'b0;
    flush    = 1'b0;
    check("fl_acc.busy", busy, 0);

    // Asynchronous reset mid-BUSY.
    drive(32'hDEADBEEF, 5'd9, 5'b00001, 0, 1, 0, 1, 0);
    in_valid = 1'b1;
    @(negedge g_clk);
    in_valid = 1'b0;
    @(negedge g_clk);
    #2 g_resetn = 1'b0;
    #1;
    check("arst.vld", out_valid, 0);
    check("arst.rdy", in_ready, 1);
    check("arst.busy", busy, 0);
    check("arst.res", result, 0);
    @(negedge g_clk);
    g_resetn = 1'b1;

    for (int i = 0; i < 200; i++) begin
      rp  = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'(1 << $urandom_range(0, 4));
      sel = $urandom_range(0, 3);
      s0  = (sel < 2);
      r0  = !s0;
      l0  = sel[0];
      r1  = !l0;
      if ($urandom_range(0, 9) == 0) begin
        s0 = 1'($urandom); r0 = 1'($urandom); l0 = 1'($urandom); r1 = 1'($urandom);
      end
      ar = 1'b0;
`ifdef P_SHFROT_ARITH_EN
      ar = 1'($urandom);
`endif
      rs = 5'($urandom);
      ra = $urandom;
      run_op("rnd", ra, rs, rp, s0, r0, l0, r1, ar, $urandom_range(0, 2), got);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
